d_sramlike2axi: RTL

D_SRAMLIKE2AXI -- requirements
Module: d_sramlike2axi

---
 rtl/d_sramlike2axi.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/d_sramlike2axi.sv
// -----------------------------------------------------------------------------
// d_sramlike2axi
//
// Bridges the data-cache side sram-like request/response handshake onto a
// single-beat AXI master. Only one transaction is in flight at a time: a
// request is accepted in IDLE, its attributes are captured, the matching AXI
// channels are driven, and the cache sees data_data_ok when the read data or
// the write response returns.
//
// Ports
//   clk, resetn            single clock, synchronous active-low reset
//   data_req/wr/size/addr/wdata
//                          sram-like request from the d-cache
//   data_addr_ok           request accepted this cycle
//   data_data_ok           transaction completed this cycle
//   data_rdata             read data, valid together with data_data_ok
//   ar*/r*                 AXI read address / read data channels
//   aw*/w*/b*              AXI write address / write data / write response
//                          (wlast, len, burst and ids are tied off outside)
// -----------------------------------------------------------------------------
module d_sramlike2axi #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,

  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rvalid,
  output logic              rready,

  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WSEND = 3'd3,
    WRESP = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              aw_done, aw_done_nx;
  logic              w_done, w_done_nx;

  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              aw_fire;
  logic              w_fire;

  // A request is only taken in IDLE; attributes are captured on that edge and
  // the data_* inputs are ignored until the bridge returns to IDLE.
  assign accept       = resetn & data_req & (state == IDLE);
  assign data_addr_ok = accept;

  // Read data is forwarded straight through; it is only meaningful in the
  // cycle data_data_ok is high.
  assign data_rdata = rdata;

  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign awsize  = {1'b0, size_q};
  assign wdata   = wdata_q;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  // ---------------------------------------------------------------------------
  // State and captured request
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      // NOTE: the captured request is plain flops, not a memory, so clearing
      // it in reset is cheap and keeps the AXI payload buses at a known value.
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nx;
      aw_done <= aw_done_nx;
      w_done  <= w_done_nx;
      if (accept) begin
        wr_q    <= data_wr;
        size_q  <= data_size;
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    aw_done_nx = aw_done;
    w_done_nx  = w_done;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = data_wr ? WSEND : RADDR;
        end
      end

      RADDR: begin
        if (arvalid & arready) begin
          state_nx = RDATA;
        end
      end

      RDATA: begin
        if (rvalid) begin
          state_nx = IDLE;
        end
      end

      WSEND: begin
        // The two write channels complete independently; the flags remember
        // which one is already done so its valid stays low afterwards. Both
        // may finish in the same cycle.
        if ((aw_done | aw_fire) & (w_done | w_fire)) begin
          state_nx   = WRESP;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
        end else begin
          aw_done_nx = aw_done | aw_fire;
          w_done_nx  = w_done | w_fire;
        end
      end

      WRESP: begin
        // bresp is not inspected; any response ends the transaction.
        if (bvalid) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Channel controls. Everything is qualified by resetn so that no valid,
  // ready or completion strobe can escape during a reset cycle, even though
  // the state register only clears on the edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    data_data_ok = 1'b0;

    if (resetn) begin
      unique case (state)
        RADDR: arvalid = 1'b1;
        RDATA: begin
          rready       = 1'b1;
          data_data_ok = rvalid;
        end
        WSEND: begin
          awvalid = ~aw_done;
          wvalid  = ~w_done;
        end
        WRESP: begin
          bready       = 1'b1;
          data_data_ok = bvalid;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write strobes from the captured size and low address bits. Size 2'b11 is
  // not a legal cache request and is handled as a full word.
  // ---------------------------------------------------------------------------
  always_comb begin
    wstrb = 4'b1111;
    unique case (size_q)
      2'b00:   wstrb = 4'b0001 << addr_q[1:0];
      2'b01:   wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

endmodule
